// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the 12-bit program counter and sequences fetch,
// execute and operand cycles for one- and two-byte instructions.
module fetch_sequencer #(
  parameter logic [11:0] RESET_VECTOR = 12'h000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        run,
  input  logic [7:0]  rom_byte,
  input  logic [7:0]  instr_byte,
  input  logic        two_byte,
  input  logic        jump_taken,
  input  logic        halt_req,
  output logic [11:0] PC,
  output logic        fetch_en,
  output logic        exec_en,
  output logic        phase,
  output logic        halted
);

  localparam int unsigned PC_W = 12;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_EXEC    = 2'd1,
    S_OPERAND = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jump_target;

  // Only the operand nibble of the instruction byte forms part of the target.
  logic unused_instr_hi;
  assign unused_instr_hi = ^instr_byte[7:4];

  // Increment wraps modulo 4096; the jump target is nibble:byte with no carry.
  assign pc_inc      = PC + PC_W'(1);
  assign jump_target = {instr_byte[3:0], rom_byte};

  // State and PC register; run=0 freezes both, HALT is left only by reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_FETCH;
      PC    <= RESET_VECTOR;
    end else if (run) begin
      case (state)
        S_FETCH: begin
          PC    <= pc_inc;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (two_byte)      state <= S_OPERAND;
          else if (halt_req) state <= S_HALT;
          else               state <= S_FETCH;
        end
        S_OPERAND: begin
          PC    <= jump_taken ? jump_target : pc_inc;
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Strobes decoded from the registered state and run; all forced low in reset.
  always_comb begin
    fetch_en = 1'b0;
    exec_en  = 1'b0;
    phase    = 1'b0;
    halted   = 1'b0;
    if (!RESET) begin
      phase  = (state != S_FETCH);
      halted = (state == S_HALT);
      if (run) begin
        case (state)
          S_FETCH:   fetch_en = 1'b1;
          S_EXEC:    exec_en  = !two_byte && !halt_req;
          S_OPERAND: exec_en  = 1'b1;
          default:   exec_en  = 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: ROM, fetch register and decoder live here,
// with an instruction-step reference model checked every cycle.
module tb_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  rom_byte;
  logic [7:0]  instr_byte;
  logic        two_byte;
  logic        jump_taken = 1'b0;
  logic        halt_req;
  logic [11:0] PC;
  logic        fetch_en;
  logic        exec_en;
  logic        phase;
  logic        halted;

  int checks = 0;
  int failures = 0;

  logic [7:0] rom [4096];
  logic [7:0] ir = 8'h00;

  // Reference model: position within the instruction and expected PC.
  // step 0 = fetching, 1 = decoding first byte, 2 = operand byte, 3 = halted.
  int m_pc = 0;
  int m_step = 0;

  fetch_sequencer #(.RESET_VECTOR(12'h000)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .run       (run),
    .rom_byte  (rom_byte),
    .instr_byte(instr_byte),
    .two_byte  (two_byte),
    .jump_taken(jump_taken),
    .halt_req  (halt_req),
    .PC        (PC),
    .fetch_en  (fetch_en),
    .exec_en   (exec_en),
    .phase     (phase),
    .halted    (halted)
  );

  always #5 CLK = ~CLK;

  // Test decoder: bit 7 or 0x5A marks a two-byte op; 0x7F and 0xFF are HALT.
  function automatic logic dec_two(input logic [7:0] b);
    return b[7] | (b == 8'h5A);
  endfunction

  function automatic logic dec_halt(input logic [7:0] b);
    return (b == 8'h7F) | (b == 8'hFF);
  endfunction

  assign rom_byte   = rom[PC];
  assign instr_byte = ir;
  assign two_byte   = dec_two(ir);
  assign halt_req   = dec_halt(ir);

  // Fetch register captures ROM data when enabled.
  always @(posedge CLK) if (fetch_en) ir <= rom_byte;

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  // One clock with the given run/jump_taken; called and returns at a negedge.
  task automatic run_cycle(input logic r, input logic jt);
    logic e_fetch, e_exec, e_phase, e_halted;
    int n_pc, n_step;
    run = r;
    jump_taken = jt;
    #1;
    e_fetch  = r && (m_step == 0);
    e_exec   = r && (((m_step == 1) && !dec_two(ir) && !dec_halt(ir)) || (m_step == 2));
    e_phase  = (m_step != 0);
    e_halted = (m_step == 3);
    checks += 5;
    if (PC !== 12'(m_pc)) begin
      failures++; $display("FAIL cycle_pc: got %h want %h at %0t", PC, 12'(m_pc), $time);
    end
    if (fetch_en !== e_fetch) begin
      failures++; $display("FAIL cycle_fetch_en: got %b want %b at %0t", fetch_en, e_fetch, $time);
    end
    if (exec_en !== e_exec) begin
      failures++; $display("FAIL cycle_exec_en: got %b want %b at %0t", exec_en, e_exec, $time);
    end
    if (phase !== e_phase) begin
      failures++; $display("FAIL cycle_phase: got %b want %b at %0t", phase, e_phase, $time);
    end
    if (halted !== e_halted) begin
      failures++; $display("FAIL cycle_halted: got %b want %b at %0t", halted, e_halted, $time);
    end
    n_pc = m_pc;
    n_step = m_step;
    if (r) begin
      if (m_step == 0) begin
        n_pc = (m_pc + 1) % 4096;
        n_step = 1;
      end else if (m_step == 1) begin
        if (dec_two(ir))       n_step = 2;
        else if (dec_halt(ir)) n_step = 3;
        else                   n_step = 0;
      end else if (m_step == 2) begin
        n_pc = jt ? (int'(ir[3:0]) * 256 + int'(rom[m_pc])) : (m_pc + 1) % 4096;
        n_step = 0;
      end
    end
    @(posedge CLK);
    m_pc = n_pc;
    m_step = n_step;
    @(negedge CLK);
  endtask

  // Mid-cycle reset pulse with no clock edge; called and returns at a negedge.
  task automatic apply_reset();
    #2;
    RESET = 1'b1;
    run = 1'b1;
    #1;
    checks += 5;
    if (PC !== 12'h000) begin
      failures++; $display("FAIL reset_pc: got %h want 000", PC);
    end
    if (phase !== 1'b0) begin
      failures++; $display("FAIL reset_phase: got %b want 0", phase);
    end
    if (halted !== 1'b0) begin
      failures++; $display("FAIL reset_halted: got %b want 0", halted);
    end
    if (fetch_en !== 1'b0) begin
      failures++; $display("FAIL reset_fetch_en: got %b want 0", fetch_en);
    end
    if (exec_en !== 1'b0) begin
      failures++; $display("FAIL reset_exec_en: got %b want 0", exec_en);
    end
    m_pc = 0;
    m_step = 0;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    run = 1'b1;
    #1;
    checks += 4;
    if (PC !== 12'h000) begin
      failures++; $display("FAIL por_pc: got %h want 000", PC);
    end
    if (fetch_en !== 1'b0) begin
      failures++; $display("FAIL por_fetch_en: got %b want 0", fetch_en);
    end
    if (phase !== 1'b0) begin
      failures++; $display("FAIL por_phase: got %b want 0", phase);
    end
    if (halted !== 1'b0) begin
      failures++; $display("FAIL por_halted: got %b want 0", halted);
    end
    @(negedge CLK);
    RESET = 1'b0;
    m_pc = 0;
    m_step = 0;
  endtask

  task automatic test_sequential();
    clear_rom();
    apply_reset();
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b0);
    checks++;
    if (PC !== 12'h002) begin
      failures++; $display("FAIL seq_pc_after4: got %h want 002", PC);
    end
  endtask

  task automatic test_two_byte_taken();
    clear_rom();
    rom[12'h000] = 8'h80; rom[12'h001] = 8'h10;
    rom[12'h010] = 8'h5A; rom[12'h011] = 8'h3C;
    apply_reset();
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1);
    checks++;
    if (PC !== 12'h010) begin
      failures++; $display("FAIL taken_setup_pc: got %h want 010", PC);
    end
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1);
    checks++;
    if (PC !== 12'hA3C) begin
      failures++; $display("FAIL taken_target: got %h want a3c", PC);
    end
  endtask

  task automatic test_two_byte_not_taken();
    clear_rom();
    rom[12'h000] = 8'h80; rom[12'h001] = 8'h10;
    rom[12'h010] = 8'h5A; rom[12'h011] = 8'h3C; rom[12'h012] = 8'h33;
    apply_reset();
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0);
    checks++;
    if (PC !== 12'h012) begin
      failures++; $display("FAIL not_taken_pc: got %h want 012", PC);
    end
    run_cycle(1'b1, 1'b0);
    checks++;
    if (ir !== 8'h33) begin
      failures++; $display("FAIL not_taken_next_fetch: got %h want 33", ir);
    end
  endtask

  task automatic test_wrap();
    clear_rom();
    rom[12'h000] = 8'h8F; rom[12'h001] = 8'hFF;
    apply_reset();
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1);
    checks++;
    if (PC !== 12'hFFF) begin
      failures++; $display("FAIL wrap1_setup: got %h want fff", PC);
    end
    run_cycle(1'b1, 1'b0);
    checks++;
    if (PC !== 12'h000) begin
      failures++; $display("FAIL wrap1_fetch: got %h want 000", PC);
    end
    run_cycle(1'b1, 1'b0);

    clear_rom();
    rom[12'h000] = 8'h8F; rom[12'h001] = 8'hFE; rom[12'hFFE] = 8'h81;
    apply_reset();
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0);
    checks++;
    if (PC !== 12'h000) begin
      failures++; $display("FAIL wrap2_operand: got %h want 000", PC);
    end
  endtask

  task automatic test_halt();
    clear_rom();
    rom[12'h000] = 8'h7F;
    apply_reset();
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    checks++;
    if (halted !== 1'b1) begin
      failures++; $display("FAIL halt_entered: got %b want 1", halted);
    end
    for (int i = 0; i < 20; i++) run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    checks++;
    if (PC !== 12'h001) begin
      failures++; $display("FAIL halt_pc_frozen: got %h want 001", PC);
    end
    apply_reset();
    run_cycle(1'b1, 1'b0);
  endtask

  task automatic test_stall_and_reset();
    clear_rom();
    rom[12'h000] = 8'h80; rom[12'h001] = 8'h55;
    apply_reset();
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'($urandom_range(0, 1)));
    checks++;
    if (PC !== 12'h001 || phase !== 1'b1) begin
      failures++; $display("FAIL stall_hold: got pc=%h phase=%b want pc=001 phase=1", PC, phase);
    end
    apply_reset();
    run_cycle(1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      if (m_step == 3 && $urandom_range(0, 7) == 0) apply_reset();
      else run_cycle(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_sequential();
    test_two_byte_taken();
    test_two_byte_not_taken();
    test_wrap();
    test_halt();
    test_stall_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream control stage for the 8-bit fetch register.
- Owns the 12-bit program counter (PC) that addresses the 4K x 8 program ROM.
- Generates the fetch-register capture enable and the execute strobe.
- Sequences one-byte and two-byte instructions: a two-byte jump is the low nibble of the instruction byte plus the following ROM byte.

Parameters:
- RESET_VECTOR, 12'h000, PC value loaded on reset.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- run  input  1  global advance enable; 0 freezes state and PC.
- rom_byte  input  8  program ROM data at address PC, combinational from ROM.
- instr_byte  input  8  current fetch-register output; bits [3:0] are the operand nibble.
- two_byte  input  1  decode flag: the instruction in instr_byte carries a second byte.
- jump_taken  input  1  decode/condition result: the jump is taken; sampled in S_OPERAND only.
- halt_req  input  1  decode flag: the instruction is HALT; sampled in S_EXEC only.
- PC  output  12  program ROM address.
- fetch_en  output  1  enable for the fetch register; high only in S_FETCH with run=1.
- exec_en  output  1  one-cycle strobe: the instruction executes this cycle.
- phase  output  1  0 in S_FETCH, 1 in all other states.
- halted  output  1  high in S_HALT.

Behaviour:
- States: S_FETCH, S_EXEC, S_OPERAND, S_HALT. State is 2-bit, registered.
- Reset (RESET=1 at any time, asynchronous, also mid-instruction):
  - state=S_FETCH, PC=RESET_VECTOR.
  - fetch_en=0, exec_en=0, phase=0, halted=0 while RESET is held.
- All outputs are decoded from registered state and run, not from decode inputs. Exception: exec_en in S_EXEC also depends on two_byte and halt_req.
- run=0: state and PC hold; fetch_en=0 and exec_en=0 in all states.
- S_FETCH, run=1:
  - fetch_en=1, so the fetch register captures rom_byte=ROM[PC] on this edge.
  - PC<=PC+1; next state S_EXEC.
- S_EXEC, run=1: decode inputs reflect the newly captured instr_byte.
  - two_byte=1: exec_en=0; next S_OPERAND; PC unchanged (it already points at the second byte).
  - two_byte=0, halt_req=1: exec_en=0; next S_HALT; PC unchanged.
  - two_byte=0, halt_req=0: exec_en=1; next S_FETCH.
  - Priority: two_byte over halt_req.
- S_OPERAND, run=1:
  - exec_en=1.
  - jump_taken=1: PC<={instr_byte[3:0], rom_byte}.
  - jump_taken=0: PC<=PC+1, skipping the second byte.
  - Next state S_FETCH.
- S_HALT: all strobes 0, halted=1, PC frozen; exits only via RESET.
- Arithmetic: PC increment is modulo 4096; 12'hFFF+1 = 12'h000, with no flag.
- Jump target: exactly 12 bits, no carry or sign handling.
- Latency:
  - One-byte instruction: 2 cycles (FETCH, EXEC).
  - Two-byte instruction: 3 cycles (FETCH, EXEC, OPERAND).
- Invalid state encoding: next state S_FETCH, PC unchanged.

Test Plan:
- Reset then run=1, all decode inputs 0: PC 0x000, 0x001, 0x001, 0x002 over 4 edges; fetch_en pattern 1,0,1,0; exec_en pattern 0,1,0,1; phase toggles.
- Two-byte taken: PC=0x010, instr_byte=0x5A, two_byte=1, rom_byte at 0x011 = 0x3C, jump_taken=1 -> after 3 edges PC=0xA3C; exec_en high only in S_OPERAND.
- Two-byte not taken: same setup with jump_taken=0 -> PC=0x012 after 3 edges; next fetch reads address 0x012.
- Wrap: PC=0xFFF, one-byte instruction -> PC=0x000 after FETCH.
- Wrap: PC=0xFFE, two-byte instruction not taken -> PC=0x000 after OPERAND.
- Halt: halt_req=1 in S_EXEC -> halted=1, PC frozen for 20 cycles regardless of run; RESET pulse -> PC=RESET_VECTOR, halted=0.
- Stall and reset: run=0 for 5 cycles in S_OPERAND -> PC and state hold, exec_en=0. RESET asserted mid-cycle with no clock edge -> PC=0x000, state S_FETCH immediately.
